// File: rtl/axi_id_compact_if.sv
// ID-only AXI AW/B/AR/R handshake bundle around axi_id_compact.
// Signal names follow the block's port list; the slave modport is the compactor's view.
interface axi_id_compact_if #(
    parameter int unsigned SlvIdWidth = 6,
    parameter int unsigned MstIdWidth = 2
);
    logic [SlvIdWidth-1:0] slv_aw_id_i;
    logic                  slv_aw_valid_i;
    logic                  slv_aw_ready_o;
    logic [MstIdWidth-1:0] mst_aw_id_o;
    logic                  mst_aw_valid_o;
    logic                  mst_aw_ready_i;
    logic [MstIdWidth-1:0] mst_b_id_i;
    logic                  mst_b_valid_i;
    logic                  mst_b_ready_o;
    logic [SlvIdWidth-1:0] slv_b_id_o;
    logic                  slv_b_valid_o;
    logic                  slv_b_ready_i;
    logic [SlvIdWidth-1:0] slv_ar_id_i;
    logic                  slv_ar_valid_i;
    logic                  slv_ar_ready_o;
    logic [MstIdWidth-1:0] mst_ar_id_o;
    logic                  mst_ar_valid_o;
    logic                  mst_ar_ready_i;
    logic [MstIdWidth-1:0] mst_r_id_i;
    logic                  mst_r_last_i;
    logic                  mst_r_valid_i;
    logic                  mst_r_ready_o;
    logic [SlvIdWidth-1:0] slv_r_id_o;
    logic                  slv_r_valid_o;
    logic                  slv_r_ready_i;

    modport slave (
        input  slv_aw_id_i, slv_aw_valid_i, mst_aw_ready_i,
        output slv_aw_ready_o, mst_aw_id_o, mst_aw_valid_o,
        input  mst_b_id_i, mst_b_valid_i, slv_b_ready_i,
        output mst_b_ready_o, slv_b_id_o, slv_b_valid_o,
        input  slv_ar_id_i, slv_ar_valid_i, mst_ar_ready_i,
        output slv_ar_ready_o, mst_ar_id_o, mst_ar_valid_o,
        input  mst_r_id_i, mst_r_last_i, mst_r_valid_i, slv_r_ready_i,
        output mst_r_ready_o, slv_r_id_o, slv_r_valid_o
    );

    modport master (
        output slv_aw_id_i, slv_aw_valid_i, mst_aw_ready_i,
        input  slv_aw_ready_o, mst_aw_id_o, mst_aw_valid_o,
        output mst_b_id_i, mst_b_valid_i, slv_b_ready_i,
        input  mst_b_ready_o, slv_b_id_o, slv_b_valid_o,
        output slv_ar_id_i, slv_ar_valid_i, mst_ar_ready_i,
        input  slv_ar_ready_o, mst_ar_id_o, mst_ar_valid_o,
        output mst_r_id_i, mst_r_last_i, mst_r_valid_i, slv_r_ready_i,
        input  mst_r_ready_o, slv_r_id_o, slv_r_valid_o
    );
endinterface

// File: rtl/axi_id_compact.sv
// AXI ID compactor: wide slave-port IDs are remapped onto a small table index and restored on responses.
// Optional AXI_ID_COMPACT_ERR_EN absorbs responses to unmapped entries and raises a sticky err_o.

// One remap table (request channel + its response channel).
// Handshake: a transfer happens in a cycle where valid and ready are both high.
module axi_id_compact_table #(
    parameter int unsigned SlvIdW  = 6,
    parameter int unsigned MstIdW  = 2,
    parameter int unsigned MaxTxns = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SlvIdW-1:0] req_id_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [MstIdW-1:0] mst_req_id_o,
    output logic              mst_req_valid_o,
    input  logic              mst_req_ready_i,
    input  logic [MstIdW-1:0] rsp_id_i,
    input  logic              rsp_last_i,
    input  logic              rsp_valid_i,
    output logic              rsp_ready_o,
    output logic [SlvIdW-1:0] slv_rsp_id_o,
    output logic              slv_rsp_valid_o,
    input  logic              slv_rsp_ready_i
`ifdef AXI_ID_COMPACT_ERR_EN
    ,
    output logic              err_o
`endif
);
    localparam int NumEntries = 2 ** MstIdW;
    localparam int CntW = $clog2(MaxTxns + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    logic              valid_q [NumEntries];
    logic              valid_d [NumEntries];
    logic [SlvIdW-1:0] id_q    [NumEntries];
    logic [SlvIdW-1:0] id_d    [NumEntries];
    logic [CntW-1:0]   cnt_q   [NumEntries];
    logic [CntW-1:0]   cnt_d   [NumEntries];

    logic              hit, hit_full, free_found, can_acc, req_hs, rsp_hs, rsp_mapped;
    logic [MstIdW-1:0] hit_idx, free_idx, sel_idx;

    // Lookup sees registered state only, so a freed entry is reusable one cycle later.
    always_comb begin
        hit        = 1'b0;
        hit_full   = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (!hit && valid_q[i] && (id_q[i] == req_id_i)) begin
                hit      = 1'b1;
                hit_idx  = MstIdW'(i);
                hit_full = (cnt_q[i] == MaxCnt);
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = MstIdW'(i);
            end
        end
        can_acc         = hit ? !hit_full : free_found;
        sel_idx         = hit ? hit_idx : free_idx;
        mst_req_id_o    = sel_idx;
        mst_req_valid_o = req_valid_i & can_acc;
        req_ready_o     = mst_req_ready_i & can_acc;
        req_hs          = req_valid_i & req_ready_o;
    end

    always_comb begin
        rsp_mapped   = valid_q[rsp_id_i];
        slv_rsp_id_o = id_q[rsp_id_i];
`ifdef AXI_ID_COMPACT_ERR_EN
        slv_rsp_valid_o = rsp_valid_i & rsp_mapped;
        rsp_ready_o     = rsp_mapped ? slv_rsp_ready_i : 1'b1;
`else
        slv_rsp_valid_o = rsp_valid_i;
        rsp_ready_o     = slv_rsp_ready_i;
`endif
        rsp_hs = rsp_valid_i & rsp_ready_o;
    end

    always_comb begin
        for (int i = 0; i < NumEntries; i++) begin
            logic inc, dec;
            valid_d[i] = valid_q[i];
            id_d[i]    = id_q[i];
            cnt_d[i]   = cnt_q[i];
            inc = req_hs && (sel_idx == MstIdW'(i));
            dec = rsp_hs && rsp_last_i && (rsp_id_i == MstIdW'(i)) && (cnt_q[i] != '0);
            if (inc) begin
                valid_d[i] = 1'b1;
                id_d[i]    = req_id_i;
            end
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!inc && dec) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
                if (cnt_q[i] == CntW'(1)) valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumEntries; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef AXI_ID_COMPACT_ERR_EN
    logic err_q, err_d;
    assign err_d = err_q | (rsp_hs & ~rsp_mapped);
    assign err_o = err_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end
`endif
endmodule

module axi_id_compact #(
    parameter int unsigned AxiSlvPortIdWidth = 6,
    parameter int unsigned AxiMstPortIdWidth = 2,
    parameter int unsigned MaxTxnsPerId      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    axi_id_compact_if.slave  bus
`ifdef AXI_ID_COMPACT_ERR_EN
    ,
    output logic             err_o
`endif
);
`ifdef AXI_ID_COMPACT_ERR_EN
    logic wr_err, rd_err;
    assign err_o = wr_err | rd_err;
`endif

    axi_id_compact_table #(
        .SlvIdW (AxiSlvPortIdWidth),
        .MstIdW (AxiMstPortIdWidth),
        .MaxTxns(MaxTxnsPerId)
    ) i_wr_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_id_i       (bus.slv_aw_id_i),
        .req_valid_i    (bus.slv_aw_valid_i),
        .req_ready_o    (bus.slv_aw_ready_o),
        .mst_req_id_o   (bus.mst_aw_id_o),
        .mst_req_valid_o(bus.mst_aw_valid_o),
        .mst_req_ready_i(bus.mst_aw_ready_i),
        .rsp_id_i       (bus.mst_b_id_i),
        .rsp_last_i     (1'b1),
        .rsp_valid_i    (bus.mst_b_valid_i),
        .rsp_ready_o    (bus.mst_b_ready_o),
        .slv_rsp_id_o   (bus.slv_b_id_o),
        .slv_rsp_valid_o(bus.slv_b_valid_o),
        .slv_rsp_ready_i(bus.slv_b_ready_i)
`ifdef AXI_ID_COMPACT_ERR_EN
        ,
        .err_o          (wr_err)
`endif
    );

    axi_id_compact_table #(
        .SlvIdW (AxiSlvPortIdWidth),
        .MstIdW (AxiMstPortIdWidth),
        .MaxTxns(MaxTxnsPerId)
    ) i_rd_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_id_i       (bus.slv_ar_id_i),
        .req_valid_i    (bus.slv_ar_valid_i),
        .req_ready_o    (bus.slv_ar_ready_o),
        .mst_req_id_o   (bus.mst_ar_id_o),
        .mst_req_valid_o(bus.mst_ar_valid_o),
        .mst_req_ready_i(bus.mst_ar_ready_i),
        .rsp_id_i       (bus.mst_r_id_i),
        .rsp_last_i     (bus.mst_r_last_i),
        .rsp_valid_i    (bus.mst_r_valid_i),
        .rsp_ready_o    (bus.mst_r_ready_o),
        .slv_rsp_id_o   (bus.slv_r_id_o),
        .slv_rsp_valid_o(bus.slv_r_valid_o),
        .slv_rsp_ready_i(bus.slv_r_ready_i)
`ifdef AXI_ID_COMPACT_ERR_EN
        ,
        .err_o          (rd_err)
`endif
    );
endmodule

// File: tb/tb_axi_id_compact.sv
// Directed bench for axi_id_compact: write/read remapping, same-ID stalls, exhaustion and burst release.
module tb_axi_id_compact;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_passed = 0;

    always #5 clk = ~clk;

    axi_id_compact_if #(.SlvIdWidth(6), .MstIdWidth(2)) bus ();

`ifdef AXI_ID_COMPACT_ERR_EN
    logic err;
`endif

    axi_id_compact #(
        .AxiSlvPortIdWidth(6),
        .AxiMstPortIdWidth(2),
        .MaxTxnsPerId     (4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
`ifdef AXI_ID_COMPACT_ERR_EN
        ,
        .err_o (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.slv_aw_id_i = '0; bus.slv_aw_valid_i = 1'b0; bus.mst_aw_ready_i = 1'b0;
        bus.mst_b_id_i = '0;  bus.mst_b_valid_i = 1'b0;  bus.slv_b_ready_i = 1'b0;
        bus.slv_ar_id_i = '0; bus.slv_ar_valid_i = 1'b0; bus.mst_ar_ready_i = 1'b0;
        bus.mst_r_id_i = '0;  bus.mst_r_last_i = 1'b0;   bus.mst_r_valid_i = 1'b0;
        bus.slv_r_ready_i = 1'b0;
    endtask

    task automatic aw(input logic [5:0] id, input logic rdy);
        bus.slv_aw_id_i = id; bus.slv_aw_valid_i = 1'b1; bus.mst_aw_ready_i = rdy;
    endtask

    task automatic ar(input logic [5:0] id, input logic rdy);
        bus.slv_ar_id_i = id; bus.slv_ar_valid_i = 1'b1; bus.mst_ar_ready_i = rdy;
    endtask

    task automatic b(input logic [1:0] idx, input logic rdy);
        bus.mst_b_id_i = idx; bus.mst_b_valid_i = 1'b1; bus.slv_b_ready_i = rdy;
    endtask

    task automatic r(input logic [1:0] idx, input logic last);
        bus.mst_r_id_i = idx; bus.mst_r_last_i = last; bus.mst_r_valid_i = 1'b1;
        bus.slv_r_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_aw_valid", 32'(bus.mst_aw_valid_o), 0);
        check("rst_ar_valid", 32'(bus.mst_ar_valid_o), 0);
        check("rst_b_valid", 32'(bus.slv_b_valid_o), 0);
        check("rst_r_valid", 32'(bus.slv_r_valid_o), 0);
        check("rst_aw_id", 32'(bus.mst_aw_id_o), 0);
        check("rst_b_id", 32'(bus.slv_b_id_o), 0);
        check("rst_r_id", 32'(bus.slv_r_id_o), 0);

        // single write
        aw(6'h2A, 1'b1); #1;
        check("w1_aw_id", 32'(bus.mst_aw_id_o), 0);
        check("w1_aw_valid", 32'(bus.mst_aw_valid_o), 1);
        check("w1_aw_ready", 32'(bus.slv_aw_ready_o), 1);
        cycle(); idle();
        b(2'd0, 1'b0); #1;
        check("w1_b_id", 32'(bus.slv_b_id_o), 32'h2A);
        check("w1_b_ready_low", 32'(bus.mst_b_ready_o), 0);
        cycle();
        b(2'd0, 1'b1); #1;
        check("w1_b_valid", 32'(bus.slv_b_valid_o), 1);
        check("w1_b_ready", 32'(bus.mst_b_ready_o), 1);
        cycle(); idle();
        aw(6'h05, 1'b0); #1;
        check("w1_entry0_free", 32'(bus.mst_aw_id_o), 0);
        check("w1_no_ready", 32'(bus.slv_aw_ready_o), 0);

        // same-ID reuse up to the per-entry limit
        for (int i = 0; i < 4; i++) begin
            aw(6'h05, 1'b1); #1;
            check($sformatf("reuse%0d_id", i), 32'(bus.mst_aw_id_o), 0);
            check($sformatf("reuse%0d_ready", i), 32'(bus.slv_aw_ready_o), 1);
            cycle();
        end
        #1;
        check("full_ready", 32'(bus.slv_aw_ready_o), 0);
        check("full_valid", 32'(bus.mst_aw_valid_o), 0);
        b(2'd0, 1'b1); #1;
        check("full_b_id", 32'(bus.slv_b_id_o), 32'h05);
        check("full_still_stall", 32'(bus.slv_aw_ready_o), 0);
        cycle();
        bus.mst_b_valid_i = 1'b0; #1;
        check("full_released_ready", 32'(bus.slv_aw_ready_o), 1);
        check("full_released_id", 32'(bus.mst_aw_id_o), 0);
        cycle(); idle();

        // drain to cnt=1, then request and response in the same cycle
        for (int i = 0; i < 3; i++) begin
            b(2'd0, 1'b1);
            cycle();
        end
        aw(6'h05, 1'b1); b(2'd0, 1'b1); #1;
        check("simul_aw_ready", 32'(bus.slv_aw_ready_o), 1);
        check("simul_b_id", 32'(bus.slv_b_id_o), 32'h05);
        cycle(); idle();
        aw(6'h07, 1'b0); #1;
        check("simul_entry0_held", 32'(bus.mst_aw_id_o), 1);
        b(2'd0, 1'b1);
        cycle(); idle();
        aw(6'h33, 1'b0); #1;
        check("simul_cnt_was_1", 32'(bus.mst_aw_id_o), 0);
        idle();

        // read table exhaustion
        for (int i = 0; i < 4; i++) begin
            ar(6'(6'h10 + i), 1'b1); #1;
            check($sformatf("ex%0d_ar_id", i), 32'(bus.mst_ar_id_o), 32'(i));
            cycle();
        end
        ar(6'h14, 1'b1); #1;
        check("ex_stall_ready", 32'(bus.slv_ar_ready_o), 0);
        check("ex_stall_valid", 32'(bus.mst_ar_valid_o), 0);
        r(2'd2, 1'b1); #1;
        check("ex_r_id", 32'(bus.slv_r_id_o), 32'h12);
        check("ex_no_same_cycle", 32'(bus.slv_ar_ready_o), 0);
        cycle();
        bus.mst_r_valid_i = 1'b0; #1;
        check("ex_alloc_ready", 32'(bus.slv_ar_ready_o), 1);
        check("ex_alloc_id", 32'(bus.mst_ar_id_o), 2);
        cycle(); idle();

        // 3-beat R burst on index 1
        for (int i = 0; i < 2; i++) begin
            r(2'd1, 1'b0); #1;
            check($sformatf("burst%0d_id", i), 32'(bus.slv_r_id_o), 32'h11);
            check($sformatf("burst%0d_ready", i), 32'(bus.mst_r_ready_o), 1);
            cycle();
        end
        bus.mst_r_valid_i = 1'b0;
        ar(6'h15, 1'b0); #1;
        check("burst_not_freed", 32'(bus.mst_ar_valid_o), 0);
        r(2'd1, 1'b1); #1;
        check("burst_last_id", 32'(bus.slv_r_id_o), 32'h11);
        cycle();
        bus.mst_r_valid_i = 1'b0; #1;
        check("burst_freed_valid", 32'(bus.mst_ar_valid_o), 1);
        check("burst_freed_id", 32'(bus.mst_ar_id_o), 1);
        idle();

`ifdef AXI_ID_COMPACT_ERR_EN
        do_reset();
        #1;
        check("err_rst", 32'(err), 0);
        b(2'd3, 1'b0); #1;
        check("err_absorb_ready", 32'(bus.mst_b_ready_o), 1);
        check("err_absorb_valid", 32'(bus.slv_b_valid_o), 0);
        check("err_not_yet", 32'(err), 0);
        cycle(); idle(); #1;
        check("err_set", 32'(err), 1);
        cycle(); cycle(); #1;
        check("err_held", 32'(err), 1);
        do_reset();
        #1;
        check("err_cleared", 32'(err), 0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
